// File: rtl/if_pc_bp_pkg.sv
// Shared definitions for the if_pc_bp fetch PC generator and its BTB.
// Holds the address bus width, reset PC default, 2-bit counter encodings,
// stall constants, the BTB update request struct and the counter step helper.
package if_pc_bp_pkg;

  localparam int InstAddrBus = 32;

  typedef logic [InstAddrBus-1:0] inst_addr_t;

  localparam inst_addr_t RESET_PC_DEF = 32'h0000_0000;

  localparam logic Stall    = 1'b1;
  localparam logic NotStall = 1'b0;

  // 2-bit saturating direction counter
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_cnt_e;

  // Resolution from EX, used to train the BTB
  typedef struct packed {
    logic       en;
    inst_addr_t pc;
    logic       taken;
    inst_addr_t target;
  } btb_upd_t;

  // Step a counter one notch towards the resolved direction, clamping at the ends.
  function automatic bp_cnt_e bp_sat(input bp_cnt_e c, input logic taken);
    bp_cnt_e r;
    r = c;
    if (taken && (c != ST))
      r = bp_cnt_e'(c + 2'd1);
    else if (!taken && (c != SNT))
      r = bp_cnt_e'(c - 2'd1);
    return r;
  endfunction

endpackage

// File: rtl/if_pc_bp_if.sv
// Fetch-side bus of if_pc_bp.
//   ex_*  : branch resolution / misprediction redirect coming from EX
//   if_*  : fetch PC, ROM enable and prediction going to ROM and IF/ID
// slave  : the PC generator (consumes ex_*, drives if_*)
// master : the surrounding pipeline (drives ex_*, consumes if_*)
interface if_pc_bp_if;
  import if_pc_bp_pkg::*;

  logic       ex_update_i;
  inst_addr_t ex_pc_i;
  logic       ex_taken_i;
  inst_addr_t ex_target_i;
  logic       ex_mispredict_i;
  inst_addr_t ex_redirect_pc_i;

  logic       if_ce_o;
  inst_addr_t if_pc_o;
  logic       if_prediction_o;
  inst_addr_t if_prediction_pc_o;

  modport slave (
    input  ex_update_i, ex_pc_i, ex_taken_i, ex_target_i,
    input  ex_mispredict_i, ex_redirect_pc_i,
    output if_ce_o, if_pc_o, if_prediction_o, if_prediction_pc_o
  );

  modport master (
    output ex_update_i, ex_pc_i, ex_taken_i, ex_target_i,
    output ex_mispredict_i, ex_redirect_pc_i,
    input  if_ce_o, if_pc_o, if_prediction_o, if_prediction_pc_o
  );
endinterface

// File: rtl/if_pc_bp_btb.sv
// Direct-mapped branch target buffer for if_pc_bp.
//   clk, rst   : clock, synchronous active-high reset
//   lk_pc      : lookup address (combinational read)
//   lk_hit     : entry valid and tag matches
//   lk_cnt     : direction counter of the indexed entry
//   lk_target  : stored target of the indexed entry
//   upd        : training request, written at the rising edge
// index = pc[IDX+1:2], tag = pc[31:IDX+2]. Reads see pre-update contents.
module if_pc_bp_btb
  import if_pc_bp_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  inst_addr_t lk_pc,
  output logic       lk_hit,
  output bp_cnt_e    lk_cnt,
  output inst_addr_t lk_target,
  input  btb_upd_t   upd
);

  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = InstAddrBus - IDX - 2;

  logic [ENTRIES-1:0] valid_q;
  logic [TAGW-1:0]    tag_q [ENTRIES];
  inst_addr_t         tgt_q [ENTRIES];
  bp_cnt_e            cnt_q [ENTRIES];

  logic [IDX-1:0]  lk_idx, u_idx;
  logic [TAGW-1:0] lk_tag, u_tag;
  logic            u_hit;

  // Byte-offset bits never take part in indexing
  logic unused_lsb;
  assign unused_lsb = ^{lk_pc[1:0], upd.pc[1:0]};

  assign lk_idx    = lk_pc[IDX+1:2];
  assign lk_tag    = lk_pc[InstAddrBus-1:IDX+2];
  assign lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lk_cnt    = cnt_q[lk_idx];
  assign lk_target = tgt_q[lk_idx];

  assign u_idx = upd.pc[IDX+1:2];
  assign u_tag = upd.pc[InstAddrBus-1:IDX+2];
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= WNT;
    end else if (upd.en) begin
      if (u_hit) begin
        cnt_q[u_idx] <= bp_sat(cnt_q[u_idx], upd.taken);
        if (upd.taken) tgt_q[u_idx] <= upd.target;
      end else if (upd.taken) begin
        // Taken miss replaces whatever lived in this slot
        valid_q[u_idx] <= 1'b1;
        tag_q[u_idx]   <= u_tag;
        tgt_q[u_idx]   <= upd.target;
        cnt_q[u_idx]   <= WT;
      end
    end
  end

endmodule

// File: rtl/if_pc_bp.sv
// Instruction-fetch PC generator with BTB-based next-PC prediction.
//   clk, rst  : clock, synchronous active-high reset
//   stall_i   : ctrl stall vector, bit 0 holds the PC
//   bus       : if_pc_bp_if.slave - EX resolution/redirect in, fetch PC,
//               ROM enable and prediction out
//   stat_updates_o / stat_mispredicts_o : event counters, present only when
//               IF_PC_BP_STATS_EN is defined
// Next PC: mispredict redirect > stall hold > predicted/sequential PC.
module if_pc_bp
  import if_pc_bp_pkg::*;
#(
  parameter int         BTB_ENTRIES = 16,
  parameter inst_addr_t RESET_PC    = RESET_PC_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [5:0]   stall_i,
`ifdef IF_PC_BP_STATS_EN
  output logic [31:0]  stat_updates_o,
  output logic [31:0]  stat_mispredicts_o,
`endif
  if_pc_bp_if.slave    bus
);

  logic       ce_q;
  inst_addr_t pc_q, pc_nxt, pc_seq, pred_pc;
  logic       hit, pred;
  bp_cnt_e    cnt;
  inst_addr_t tgt;
  btb_upd_t   upd;

  logic unused_ok;
  assign unused_ok = ^{stall_i[5:1], cnt[0]};

  assign upd = '{en:     bus.ex_update_i,
                 pc:     bus.ex_pc_i,
                 taken:  bus.ex_taken_i,
                 target: bus.ex_target_i};

  if_pc_bp_btb #(.ENTRIES(BTB_ENTRIES)) u_btb (
    .clk       (clk),
    .rst       (rst),
    .lk_pc     (pc_q),
    .lk_hit    (hit),
    .lk_cnt    (cnt),
    .lk_target (tgt),
    .upd       (upd)
  );

  assign pc_seq  = pc_q + 32'd4;  // wraps naturally at 2^32
  assign pred    = ce_q && hit && cnt[1];
  assign pred_pc = pred ? tgt : pc_seq;

  always_comb begin
    pc_nxt = pred_pc;
    if (bus.ex_mispredict_i)
      pc_nxt = bus.ex_redirect_pc_i;
    else if (stall_i[0] == Stall)
      pc_nxt = pc_q;
  end

  // ce comes up one cycle after reset release; PC only moves while fetching
  always_ff @(posedge clk) begin
    if (rst) begin
      ce_q <= 1'b0;
      pc_q <= RESET_PC;
    end else begin
      ce_q <= 1'b1;
      if (ce_q) pc_q <= pc_nxt;
    end
  end

  assign bus.if_ce_o            = ce_q;
  assign bus.if_pc_o            = pc_q;
  assign bus.if_prediction_o    = pred;
  assign bus.if_prediction_pc_o = pred_pc;

`ifdef IF_PC_BP_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_updates_o     <= '0;
      stat_mispredicts_o <= '0;
    end else begin
      if (bus.ex_update_i)     stat_updates_o     <= stat_updates_o + 32'd1;
      if (bus.ex_mispredict_i) stat_mispredicts_o <= stat_mispredicts_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_pc_bp.sv
module tb_if_pc_bp;
  import if_pc_bp_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] stall;
`ifdef IF_PC_BP_STATS_EN
  logic [31:0] st_upd, st_mp;
`endif

  if_pc_bp_if bus();

  if_pc_bp #(.BTB_ENTRIES(16), .RESET_PC(32'h0)) dut (
    .clk     (clk),
    .rst     (rst),
    .stall_i (stall),
`ifdef IF_PC_BP_STATS_EN
    .stat_updates_o     (st_upd),
    .stat_mispredicts_o (st_mp),
`endif
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // kind 0: fetch cycle, 1: idle cycle after reset, 2: stats (pc=updates, ppc=mispredicts)
  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] pc;
    logic        pred;
    logic [31:0] ppc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Monitor: pops one expectation per cycle, sampled on the falling edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      case (e.kind)
        2'd0: if (bus.if_ce_o !== 1'b1 || bus.if_pc_o !== e.pc ||
                  bus.if_prediction_o !== e.pred || bus.if_prediction_pc_o !== e.ppc) begin
          errors++;
          $display("FAIL fetch: got ce=%b pc=%h pred=%b ppc=%h, want ce=1 pc=%h pred=%b ppc=%h",
                   bus.if_ce_o, bus.if_pc_o, bus.if_prediction_o, bus.if_prediction_pc_o,
                   e.pc, e.pred, e.ppc);
        end
        2'd1: if (bus.if_ce_o !== 1'b0 || bus.if_pc_o !== e.pc || bus.if_prediction_o !== 1'b0) begin
          errors++;
          $display("FAIL reset_idle: got ce=%b pc=%h pred=%b, want ce=0 pc=%h pred=0",
                   bus.if_ce_o, bus.if_pc_o, bus.if_prediction_o, e.pc);
        end
        default: begin
`ifdef IF_PC_BP_STATS_EN
          if (st_upd !== e.pc || st_mp !== e.ppc) begin
            errors++;
            $display("FAIL stats: got upd=%0d mp=%0d, want upd=%0d mp=%0d",
                     st_upd, st_mp, e.pc, e.ppc);
          end
`endif
        end
      endcase
    end
  end

  task automatic clr();
    bus.ex_update_i      = 1'b0;
    bus.ex_pc_i          = '0;
    bus.ex_taken_i       = 1'b0;
    bus.ex_target_i      = '0;
    bus.ex_mispredict_i  = 1'b0;
    bus.ex_redirect_pc_i = '0;
    stall                = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    clr();
  endtask

  task automatic step(input logic [31:0] pc, input logic pred, input logic [31:0] ppc);
    exp_q.push_back('{kind: 2'd0, pc: pc, pred: pred, ppc: ppc});
    tick();
  endtask

  task automatic idle();
    exp_q.push_back('{kind: 2'd1, pc: 32'h0, pred: 1'b0, ppc: 32'h0});
    tick();
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    bus.ex_update_i = 1'b1;
    bus.ex_pc_i     = pc;
    bus.ex_taken_i  = taken;
    bus.ex_target_i = tgt;
  endtask

  task automatic mp(input logic [31:0] pc);
    bus.ex_mispredict_i  = 1'b1;
    bus.ex_redirect_pc_i = pc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle();                                        // ce low first cycle after release
    step(32'h0, 0, 32'h4);
    step(32'h4, 0, 32'h8);
    upd(32'h10, 1, 32'h40);  step(32'h8,  0, 32'hC);   // allocate 0x10 -> WT
    step(32'hC,  0, 32'h10);
    upd(32'h10, 0, 32'h0);   step(32'h10, 1, 32'h40);  // old prediction used, now WNT
    mp(32'h10);              step(32'h40, 0, 32'h44);
    upd(32'h10, 1, 32'h40);  step(32'h10, 0, 32'h14);  // WNT predicts fallthrough, -> WT
    upd(32'h10, 1, 32'h40); mp(32'h10); step(32'h14, 0, 32'h18); // -> ST
    upd(32'h10, 1, 32'h40); stall = 6'd1; step(32'h10, 1, 32'h40); // stays ST
    upd(32'h10, 1, 32'h40); stall = 6'd1; step(32'h10, 1, 32'h40); // stays ST
    upd(32'h10, 0, 32'h0);  stall = 6'd1; step(32'h10, 1, 32'h40); // ST -> WT
    upd(32'h10, 0, 32'h0);  stall = 6'd1; step(32'h10, 1, 32'h40); // WT -> WNT
    step(32'h10, 0, 32'h14);
    mp(32'h20);              step(32'h14, 0, 32'h18);
    stall = 6'b000011;       step(32'h20, 0, 32'h24);  // held
    stall = 6'b000011; mp(32'h100); step(32'h20, 0, 32'h24); // redirect beats stall
    upd(32'h50, 1, 32'h80);  step(32'h100, 0, 32'h104); // alias replaces 0x10
    mp(32'h10);              step(32'h104, 0, 32'h108);
    mp(32'h50);              step(32'h10, 0, 32'h14);   // evicted
    step(32'h50, 1, 32'h80);
    upd(32'h90, 0, 32'h0); mp(32'h50); step(32'h80, 0, 32'h84); // NT miss: no change
    mp(32'hFFFF_FFFC);       step(32'h50, 1, 32'h80);
    step(32'hFFFF_FFFC, 0, 32'h0);                      // sequential wrap
    mp(32'h103);             step(32'h0, 0, 32'h4);
    step(32'h103, 0, 32'h107);                          // misaligned pass-through

    // Reset mid-operation with a pending taken update on 0x50
    rst = 1'b1; upd(32'h50, 1, 32'h300);
    tick();
    rst = 1'b0;
    idle();
    mp(32'h50); upd(32'h200, 0, 32'h0); step(32'h0, 0, 32'h4);
    upd(32'h200, 0, 32'h0);  step(32'h50, 0, 32'h54);  // BTB cleared, update dropped
    upd(32'h200, 0, 32'h0);  step(32'h54, 0, 32'h58);
`ifdef IF_PC_BP_STATS_EN
    exp_q.push_back('{kind: 2'd2, pc: 32'd3, pred: 1'b0, ppc: 32'd1});
`endif
    @(negedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
